mac_sequencer: RTL
==================

Name: mac_sequencer

Overview:
- Initiator/driver for the MAC accumulator: buffers a job of up to DEPTH (in_data, weight) pairs and clears the MAC.
- Streams one pair per cycle into the MAC, then captures the accumulated sum and returns it on a valid/ready result port.
- Sits between the load/control fabric and one MAC instance; owns the MAC's clear line and operand inputs.

Parameters:
DATA_W, 16, width of in_data and weight operands
ACC_W, 32, width of MAC accumulator and result
DEPTH, 8, maximum pairs per job (operand buffer entries)
LEN_W, 4, width of len; must hold DEPTH+1

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
start  input  1  job request, sampled only in IDLE
len  input  LEN_W  pairs in job, legal range 1..DEPTH, sampled with start
wr_valid  input  1  load pair valid
wr_ready  output  1  load pair ready (high only in LOAD)
wr_data  input  DATA_W  operand to load
wr_weight  input  DATA_W  weight to load
mac_clr  output  1  active-high clear to the MAC's reset input
mac_in_data  output  DATA_W  operand to the MAC
mac_weight  output  DATA_W  weight to the MAC
mac_out  input  ACC_W  MAC accumulator value
res_valid  output  1  result valid
res_ready  input  1  result accepted
res_data  output  ACC_W  captured sum
busy  output  1  high whenever state != IDLE

Behaviour:
- Outputs: all registered except wr_ready and busy, which decode from the state register.
- Reset: reset low at a clock edge forces IDLE. Reset values: mac_clr=1, mac_in_data=0, mac_weight=0, res_valid=0, res_data=0, wr_ready=0, busy=0. Pointers and counters clear to 0. Buffer contents are not reset.
- Reset mid-operation: aborts the job at any state; a pending result is dropped.
- FSM states: IDLE, LOAD, CLEAR, STREAM, SETTLE, RESULT.
- IDLE:
  - mac_clr=0; operands=0.
  - start=1 with 1<=len<=DEPTH latches len, clears wr_ptr, and moves to LOAD.
  - start with len=0 or len>DEPTH is ignored; stay in IDLE.
- LOAD:
  - wr_ready=1; each wr_valid&wr_ready writes buf[wr_ptr] and increments wr_ptr.
  - Gaps in wr_valid are allowed.
  - The handshake that writes pair len-1 moves to CLEAR.
- CLEAR (1 cycle): mac_clr=1, operands=0; then go to STREAM with rd_ptr=0.
- STREAM (exactly len cycles):
  - mac_clr=0; mac_in_data/mac_weight = buf[rd_ptr].
  - The MAC accumulates at the end of each cycle; rd_ptr increments each cycle.
  - After cycle len-1, go to SETTLE.
- SETTLE (1 cycle):
  - Operands=0, so the MAC adds 0.
  - mac_out now holds the full sum; res_data<=mac_out at the end of the cycle.
  - res_valid<=1; go to RESULT.
- RESULT:
  - res_valid=1; res_data held stable.
  - res_valid&res_ready clears res_valid and returns to IDLE. res_ready may already be high when res_valid rises.
- Latency: res_valid rises len+2 clock edges after the final load handshake edge.
- start is ignored in every state except IDLE. A new job is accepted no earlier than the cycle after the result handshake.
- Operand outputs are 0 in every state except STREAM, so the MAC holds its sum outside STREAM.
- Arithmetic: unsigned; the MAC wraps modulo 2^ACC_W. No saturation or overflow flag.

Test Plan:
1. Basic job: start, len=3; load (1,2),(3,4),(5,6) -> mac_clr high for exactly 1 cycle; operands show the 3 pairs on consecutive cycles; res_valid rises 5 edges after the last load; res_data=44.
2. Back-to-back jobs: job 1 as in test 1, then start, len=1; load (7,8) -> res_data=56 (MAC cleared between jobs).
3. Back-pressure and ignored start:
   - Stimulus: wr_valid toggles 1/0 during load; res_ready held low 10 cycles after res_valid; start pulsed during RESULT.
   - Response: res_data stable, busy=1 throughout, start ignored, IDLE entered only after the handshake.
4. Wrap: len=2; pairs (65535,65535),(65535,65535) -> res_data=0xFFFC0002.
5. Reset mid-operation:
   - Stimulus: reset low during STREAM cycle 2 of len=4.
   - Response: next cycle busy=0, mac_clr=1, res_valid=0, operands=0.
   - Follow-up: after release, len=1 with (2,3) -> res_data=6.
6. Length bounds: start with len=0, then len=DEPTH+1 -> busy stays 0, wr_ready stays 0; then len=DEPTH, all pairs (1,1) -> res_data=8.

Source files
------------

// File: rtl/mac_sequencer.sv
// mac_sequencer: job sequencer for a single MAC accumulator.
// Buffers up to DEPTH (data, weight) pairs and clears the MAC. It then
// streams the pairs one per cycle, captures the final sum, and presents it
// on a valid/ready result port. Arithmetic is unsigned and the MAC wraps.
module mac_sequencer #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int DEPTH  = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] wr_weight,
  output logic              mac_clr,
  output logic [DATA_W-1:0] mac_in_data,
  output logic [DATA_W-1:0] mac_weight,
  input  logic [ACC_W-1:0]  mac_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic              busy
);

  localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
  localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_STREAM,
    S_SETTLE,
    S_RESULT
  } state_e;

  state_e state_q, state_d;

  // Job length and the load/stream counters. The counters are LEN_W wide so
  // they compare directly against len_q; their low bits index the buffer.
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [LEN_W-1:0] rd_cnt_q, rd_cnt_d;

  // Operand buffer, written during LOAD and read during STREAM.
  logic [DATA_W-1:0] data_mem_q   [DEPTH];
  logic [DATA_W-1:0] weight_mem_q [DEPTH];

  // Registered outputs toward the MAC and the result port.
  logic              mac_clr_q, mac_clr_d;
  logic [DATA_W-1:0] mac_in_data_q, mac_in_data_d;
  logic [DATA_W-1:0] mac_weight_q, mac_weight_d;
  logic              res_valid_q, res_valid_d;
  logic [ACC_W-1:0]  res_data_q, res_data_d;

  logic len_ok;
  logic wr_fire;

  assign len_ok   = (len != '0) && (len <= DEPTH_L);
  assign wr_ready = (state_q == S_LOAD);
  assign busy     = (state_q != S_IDLE);
  assign wr_fire  = wr_valid && wr_ready;

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;

    case (state_q)
      S_IDLE: begin
        if (start && len_ok) begin
          len_d    = len;
          wr_cnt_d = '0;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        if (wr_fire) begin
          wr_cnt_d = wr_cnt_q + ONE_L;
          if (wr_cnt_q == len_q - ONE_L) begin
            state_d = S_CLEAR;
          end
        end
      end
      S_CLEAR: begin
        rd_cnt_d = '0;
        state_d  = S_STREAM;
      end
      S_STREAM: begin
        rd_cnt_d = rd_cnt_q + ONE_L;
        if (rd_cnt_q == len_q - ONE_L) begin
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        // The final product landed at the last STREAM edge, so mac_out is complete here.
        res_data_d  = mac_out;
        res_valid_d = 1'b1;
        state_d     = S_RESULT;
      end
      S_RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // MAC-facing outputs are registered, so they are decoded from the state being
    // entered. That way they line up with the cycle the FSM spends in that state.
    mac_clr_d     = (state_d == S_CLEAR);
    mac_in_data_d = '0;
    mac_weight_d  = '0;
    if (state_d == S_STREAM) begin
      mac_in_data_d = data_mem_q[rd_cnt_d[PTR_W-1:0]];
      mac_weight_d  = weight_mem_q[rd_cnt_d[PTR_W-1:0]];
    end
  end

  // State, counters and registered outputs; reset aborts any job in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      len_q         <= '0;
      wr_cnt_q      <= '0;
      rd_cnt_q      <= '0;
      mac_clr_q     <= 1'b1;
      mac_in_data_q <= '0;
      mac_weight_q  <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      wr_cnt_q      <= wr_cnt_d;
      rd_cnt_q      <= rd_cnt_d;
      mac_clr_q     <= mac_clr_d;
      mac_in_data_q <= mac_in_data_d;
      mac_weight_q  <= mac_weight_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
    end
  end

  // Operand buffer write port: one pair per load handshake, contents never reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      data_mem_q[wr_cnt_q[PTR_W-1:0]]   <= wr_data;
      weight_mem_q[wr_cnt_q[PTR_W-1:0]] <= wr_weight;
    end
  end

  assign mac_clr     = mac_clr_q;
  assign mac_in_data = mac_in_data_q;
  assign mac_weight  = mac_weight_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;

endmodule
